// File: rtl/packet_downsizer.sv
// 64->32 bit transmit width translator with SOP/EOP/residual/bad sideband.
// Define PKT_DOWNSIZER_LEN_CHECK_EN to enable length/framing error checks.
module packet_downsizer #(
  parameter int IN_WIDTH  = 64,
  parameter int OUT_WIDTH = 32,
  parameter int LEN_WIDTH = 14
) (
  input  logic                 iclk,
  input  logic                 irst,
  input  logic                 ivalid,
  output logic                 iready,
  input  logic                 isop,
  input  logic                 ieop,
  input  logic [LEN_WIDTH-1:0] iplen,
  input  logic [IN_WIDTH-1:0]  idata,
  input  logic                 ibad,
  output logic                 ovalid,
  input  logic                 oready,
  output logic                 osop,
  output logic                 oeop,
  output logic [1:0]           oresidual,
  output logic [OUT_WIDTH-1:0] odata,
  output logic                 obad,
  output logic                 olen_err
);

  typedef enum logic [1:0] {
    EMPTY,
    HI,
    LO
  } state_t;

  state_t state_q, state_d;

  logic [IN_WIDTH-1:0]  hdata_q, hdata_d;
  logic                 heop_q, heop_d;
  logic                 hsingle_q, hsingle_d;
  logic [1:0]           hres_q, hres_d;
  logic                 hbad_q, hbad_d;
  logic [LEN_WIDTH-1:0] rem_q, rem_d;
  logic                 sticky_q, sticky_d;

  logic                 ovalid_q, ovalid_d;
  logic                 osop_q, osop_d;
  logic                 oeop_q, oeop_d;
  logic [1:0]           ores_q, ores_d;
  logic [OUT_WIDTH-1:0] odata_q, odata_d;
  logic                 obad_q, obad_d;

  logic                 accept;
  logic                 last_half;
  logic [LEN_WIDTH-1:0] rem_cur;
  logic                 rem_gt8;
  logic [3:0]           nbytes;
  logic                 single;
  logic                 beat_bad;
  logic                 force_bad;
  logic                 restart;

  assign last_half = (state_q == HI && hsingle_q) || state_q == LO;
  assign iready    = ~irst & (state_q == EMPTY || (oready && last_half));
  assign accept    = ivalid & iready;

  // Per-beat length bookkeeping; iplen only matters on the SOP beat.
  always_comb begin
    rem_cur  = isop ? iplen : rem_q;
    rem_gt8  = rem_cur > LEN_WIDTH'(8);
    nbytes   = (rem_cur == '0 || rem_gt8) ? 4'd8 : rem_cur[3:0];
    single   = ieop && nbytes <= 4'd4;
    beat_bad = (restart ? 1'b0 : sticky_q) | ibad | force_bad;
  end

`ifdef PKT_DOWNSIZER_LEN_CHECK_EN
  logic open_q, open_d;
  logic len_err_q, len_err_d;

  always_comb begin
    force_bad = (ieop & rem_gt8) | (~ieop & ~rem_gt8)
              | (isop & (iplen == '0));
    restart   = isop & open_q;
    len_err_d = accept & (force_bad | restart);
    open_d    = accept ? ~ieop : open_q;
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      open_q    <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      open_q    <= open_d;
      len_err_q <= len_err_d;
    end
  end

  assign olen_err = len_err_q;
`else
  assign force_bad = 1'b0;
  assign restart   = 1'b0;
  assign olen_err  = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    hdata_d   = hdata_q;
    heop_d    = heop_q;
    hsingle_d = hsingle_q;
    hres_d    = hres_q;
    hbad_d    = hbad_q;
    rem_d     = rem_q;
    sticky_d  = sticky_q;
    ovalid_d  = ovalid_q;
    osop_d    = osop_q;
    oeop_d    = oeop_q;
    ores_d    = ores_q;
    odata_d   = odata_q;
    obad_d    = obad_q;
    if (accept) begin
      hdata_d   = idata;
      heop_d    = ieop;
      hsingle_d = single;
      hres_d    = nbytes[1:0];
      hbad_d    = beat_bad;
      rem_d     = rem_gt8 ? rem_cur - LEN_WIDTH'(8) : '0;
      // bad state is captured in the held beat, so the sticky bit restarts here
      sticky_d  = ieop ? 1'b0 : beat_bad;
      state_d   = HI;
      ovalid_d  = 1'b1;
      odata_d   = idata[IN_WIDTH-1:OUT_WIDTH];
      osop_d    = isop;
      oeop_d    = single;
      ores_d    = single ? nbytes[1:0] : 2'd0;
      obad_d    = single & beat_bad;
    end else if (oready && state_q == HI && !hsingle_q) begin
      state_d = LO;
      odata_d = hdata_q[OUT_WIDTH-1:0];
      osop_d  = 1'b0;
      oeop_d  = heop_q;
      ores_d  = heop_q ? hres_q : 2'd0;
      obad_d  = heop_q & hbad_q;
    end else if (oready && last_half) begin
      state_d  = EMPTY;
      ovalid_d = 1'b0;
      osop_d   = 1'b0;
      oeop_d   = 1'b0;
      ores_d   = 2'd0;
      obad_d   = 1'b0;
    end
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      state_q   <= EMPTY;
      hdata_q   <= '0;
      heop_q    <= 1'b0;
      hsingle_q <= 1'b0;
      hres_q    <= 2'd0;
      hbad_q    <= 1'b0;
      rem_q     <= '0;
      sticky_q  <= 1'b0;
      ovalid_q  <= 1'b0;
      osop_q    <= 1'b0;
      oeop_q    <= 1'b0;
      ores_q    <= 2'd0;
      odata_q   <= '0;
      obad_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hdata_q   <= hdata_d;
      heop_q    <= heop_d;
      hsingle_q <= hsingle_d;
      hres_q    <= hres_d;
      hbad_q    <= hbad_d;
      rem_q     <= rem_d;
      sticky_q  <= sticky_d;
      ovalid_q  <= ovalid_d;
      osop_q    <= osop_d;
      oeop_q    <= oeop_d;
      ores_q    <= ores_d;
      odata_q   <= odata_d;
      obad_q    <= obad_d;
    end
  end

  assign ovalid    = ovalid_q;
  assign osop      = osop_q;
  assign oeop      = oeop_q;
  assign oresidual = ores_q;
  assign odata     = odata_q;
  assign obad      = obad_q;

endmodule

// File: tb/tb_packet_downsizer.sv
// Scoreboard bench for packet_downsizer: byte-level packet model vs DUT words.
// Honours PKT_DOWNSIZER_LEN_CHECK_EN for the length-error expectations.
module tb_packet_downsizer;

  localparam int LW = 14;
`ifdef PKT_DOWNSIZER_LEN_CHECK_EN
  localparam bit LEN_CHK = 1'b1;
`else
  localparam bit LEN_CHK = 1'b0;
`endif

  logic          iclk = 1'b0;
  logic          irst;
  logic          ivalid;
  logic          iready;
  logic          isop;
  logic          ieop;
  logic [LW-1:0] iplen;
  logic [63:0]   idata;
  logic          ibad;
  logic          ovalid;
  logic          oready;
  logic          osop;
  logic          oeop;
  logic [1:0]    oresidual;
  logic [31:0]   odata;
  logic          obad;
  logic          olen_err;

  always #5 iclk = ~iclk;

  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic [1:0]  res;
    logic        bad;
  } word_t;

  word_t exp_q[$];
  int    n_chk    = 0;
  int    n_fail   = 0;
  int    cyc      = 0;
  int    rdy_mode = 0;
  int    err_seen = 0;
  int    err_exp  = 0;

  always @(posedge iclk) cyc <= cyc + 1;

  packet_downsizer #(
    .IN_WIDTH (64),
    .OUT_WIDTH(32),
    .LEN_WIDTH(LW)
  ) dut (
    .iclk     (iclk),
    .irst     (irst),
    .ivalid   (ivalid),
    .iready   (iready),
    .isop     (isop),
    .ieop     (ieop),
    .iplen    (iplen),
    .idata    (idata),
    .ibad     (ibad),
    .ovalid   (ovalid),
    .oready   (oready),
    .osop     (osop),
    .oeop     (oeop),
    .oresidual(oresidual),
    .odata    (odata),
    .obad     (obad),
    .olen_err (olen_err)
  );

  function automatic void chk(input string nm, input logic [63:0] got,
                              input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, got, want);
    end
  endfunction

  task automatic finish_test();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  endtask

  // oready pattern generator: 0 always, 1 random, 2 toggle, 3 manual
  initial begin
    oready = 1'b0;
    forever begin
      @(posedge iclk);
      #1;
      case (rdy_mode)
        0: oready = 1'b1;
        1: oready = ($urandom_range(0, 3) != 0);
        2: oready = ~oready;
        default: ;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every output handshake
  initial begin : monitor
    logic [36:0] cur;
    logic [36:0] prev;
    logic        stall;
    word_t       w;
    stall = 1'b0;
    prev  = '0;
    forever begin
      @(negedge iclk);
      cur = {odata, osop, oeop, oresidual, obad};
      if (irst) begin
        stall = 1'b0;
      end else begin
        if (olen_err) err_seen++;
        if (stall) begin
          chk("ovalid_held", 64'(ovalid), 64'd1);
          chk("hold_stable", 64'(cur), 64'(prev));
        end
        if (ovalid && oready) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_word: got 0x%0h, want none", cur);
          end else begin
            w = exp_q.pop_front();
            chk("word", 64'(cur), 64'(w));
          end
        end
        stall = ovalid & ~oready;
        prev  = cur;
      end
    end
  end

  task automatic send_beat(input logic s, input logic e,
                           input logic [LW-1:0] pl, input logic [63:0] d,
                           input logic b, input logic xerr,
                           output int acc);
    logic got;
    int   waitc;
    waitc  = 0;
    isop   = s;
    ieop   = e;
    iplen  = pl;
    idata  = d;
    ibad   = b;
    ivalid = 1'b1;
    acc    = -1;
    while (acc < 0) begin
      @(negedge iclk);
      got = iready;
      @(posedge iclk);
      if (got) begin
        acc = cyc;
      end else begin
        waitc++;
        if (waitc > 1000) begin
          n_chk++;
          n_fail++;
          $display("FAIL accept_timeout: got no iready, want accept");
          finish_test();
        end
      end
    end
    #1;
    ivalid = 1'b0;
    if (xerr) err_exp++;
    chk("olen_err", 64'(olen_err), 64'(xerr));
  endtask

  // Packet of plen bytes split into 8-byte beats, emitted as 4-byte words
  task automatic send_pkt(input int plen, input logic [7:0] badm,
                          input int gapmax, output int acc0);
    int          eff;
    int          nb;
    int          nw;
    int          a;
    logic [63:0] d[8];
    logic        anyb;
    logic        zlen;
    word_t       w;
    eff  = (plen == 0) ? 8 : plen;
    nb   = (eff + 7) / 8;
    nw   = (eff + 3) / 4;
    zlen = LEN_CHK && (plen == 0);
    anyb = zlen;
    acc0 = 0;
    for (int i = 0; i < nb; i++) begin
      d[i] = {$urandom, $urandom};
      anyb = anyb | badm[i];
    end
    for (int k = 0; k < nw; k++) begin
      w.data = (k % 2 == 0) ? d[k/2][63:32] : d[k/2][31:0];
      w.sop  = (k == 0);
      w.eop  = (k == nw - 1);
      w.res  = w.eop ? 2'(eff % 4) : 2'd0;
      w.bad  = w.eop & anyb;
      exp_q.push_back(w);
    end
    for (int i = 0; i < nb; i++) begin
      send_beat(i == 0, i == nb - 1, LW'(plen), d[i], badm[i],
                zlen && i == 0, a);
      if (i == 0) acc0 = a;
      if (gapmax > 0) begin
        repeat ($urandom_range(0, gapmax)) @(posedge iclk);
        #1;
      end
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(posedge iclk);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d words left, want 0",
               exp_q.size());
      finish_test();
    end
    repeat (3) @(posedge iclk);
    #1;
  endtask

  initial begin
    #500000;
    n_chk++;
    n_fail++;
    $display("FAIL watchdog: got no finish, want finish");
    finish_test();
  end

  initial begin : main
    int          a0;
    int          a1;
    int          a2;
    logic [63:0] d0;
    logic [63:0] d1;
    word_t       w;

    irst   = 1'b1;
    ivalid = 1'b0;
    isop   = 1'b0;
    ieop   = 1'b0;
    iplen  = '0;
    idata  = '0;
    ibad   = 1'b0;
    repeat (3) @(posedge iclk);
    #1;
    chk("rst_ovalid", 64'(ovalid), 64'd0);
    chk("rst_iready", 64'(iready), 64'd0);
    chk("rst_outs", 64'({odata, osop, oeop, oresidual, obad}), 64'd0);
    chk("rst_len_err", 64'(olen_err), 64'd0);
    irst = 1'b0;
    @(posedge iclk);
    #1;

    // 13-byte, two beats
    rdy_mode = 0;
    send_pkt(13, 8'h00, 0, a0);
    drain();

    // 4-byte single beat; ready for next beat right away
    send_pkt(4, 8'h00, 0, a0);
    @(negedge iclk);
    chk("iready_after_single", 64'(iready), 64'd1);
    drain();

    // back-to-back 8-byte packets: one beat per two cycles
    send_pkt(8, 8'h00, 0, a0);
    send_pkt(8, 8'h00, 0, a1);
    send_pkt(8, 8'h00, 0, a2);
    chk("b2b_gap1", 64'(a1 - a0), 64'd2);
    chk("b2b_gap2", 64'(a2 - a1), 64'd2);
    drain();

    // 11-byte bad packet under stalls, then a clean one
    rdy_mode = 2;
    send_pkt(11, 8'h01, 0, a0);
    send_pkt(11, 8'h00, 0, a0);
    drain();

    // reset while the LO word is stalled
    rdy_mode = 3;
    oready   = 1'b0;
    d0       = {$urandom, $urandom};
    w        = '{data: d0[63:32], sop: 1'b1, eop: 1'b0, res: 2'd0, bad: 1'b0};
    exp_q.push_back(w);
    send_beat(1'b1, 1'b0, LW'(16), d0, 1'b0, 1'b0, a0);
    oready = 1'b1;
    @(posedge iclk);
    #1;
    oready = 1'b0;
    repeat (2) @(posedge iclk);
    #1;
    chk("lo_stalled_data", 64'(odata), 64'(d0[31:0]));
    irst = 1'b1;
    @(posedge iclk);
    #1;
    chk("rst_mid_ovalid", 64'(ovalid), 64'd0);
    chk("rst_mid_iready", 64'(iready), 64'd0);
    irst     = 1'b0;
    rdy_mode = 0;
    @(posedge iclk);
    #1;
    send_pkt(4, 8'h00, 0, a0);
    drain();

    // iplen=20 but eop on the second beat
    d0 = {$urandom, $urandom};
    d1 = {$urandom, $urandom};
    w  = '{data: d0[63:32], sop: 1'b1, eop: 1'b0, res: 2'd0, bad: 1'b0};
    exp_q.push_back(w);
    w  = '{data: d0[31:0], sop: 1'b0, eop: 1'b0, res: 2'd0, bad: 1'b0};
    exp_q.push_back(w);
    w  = '{data: d1[63:32], sop: 1'b0, eop: 1'b0, res: 2'd0, bad: 1'b0};
    exp_q.push_back(w);
    w  = '{data: d1[31:0], sop: 1'b0, eop: 1'b1, res: 2'd0, bad: LEN_CHK};
    exp_q.push_back(w);
    send_beat(1'b1, 1'b0, LW'(20), d0, 1'b0, 1'b0, a0);
    send_beat(1'b0, 1'b1, LW'(0), d1, 1'b0, LEN_CHK, a0);
    send_pkt(9, 8'h00, 0, a0);
    drain();

    // randomized traffic with random backpressure and gaps
    rdy_mode = 1;
    for (int p = 0; p < 40; p++) begin
      send_pkt($urandom_range(0, 40),
               ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'h00,
               2, a0);
    end
    drain();

    chk("olen_err_count", 64'(err_seen), 64'(err_exp));
    finish_test();
  end

endmodule

// File: doc/packet_downsizer.md
Name: packet_downsizer

Overview:
- Transmit-side width translator: accepts 64-bit packet beats with a byte length carried on the SOP beat and emits 32-bit words with SOP/EOP/residual/bad.
- It is the inverse of the 32->64 ingress translator and produces the same 32-bit sideband format that translator consumes.
- Single clock domain. Placed between the 64-bit core datapath and the 32-bit egress MAC interface. Both sides use a valid/ready handshake.

Parameters:
- IN_WIDTH, 64, input data width; fixed at 2x OUT_WIDTH.
- OUT_WIDTH, 32, output data width; 4 bytes per output word.
- LEN_WIDTH, 14, width of packet byte length.

Ports:
- iclk  input  1  clock
- irst  input  1  synchronous active-high reset
- ivalid  input  1  input beat valid
- iready  output  1  input beat accepted when ivalid & iready
- isop  input  1  first beat of packet
- ieop  input  1  last beat of packet
- iplen  input  LEN_WIDTH  packet byte length; sampled only on an accepted isop beat
- idata  input  IN_WIDTH  beat data; bits [63:32] are sent first
- ibad  input  1  packet marked bad; may assert on any beat
- ovalid  output  1  output word valid
- oready  input  1  output word accepted when ovalid & oready
- osop  output  1  first word of packet
- oeop  output  1  last word of packet
- oresidual  output  2  valid bytes in the oeop word: 0 means 4 bytes, 1-3 mean that count; 0 on non-eop words
- odata  output  OUT_WIDTH  word data
- obad  output  1  asserted with oeop if any beat of the packet had ibad
- olen_err  output  1  one-cycle length/framing error pulse (see Optional Feature)

Behaviour:
- Reset (irst sampled high at posedge): state=EMPTY; ovalid, osop, oeop, obad, olen_err=0; oresidual=0; odata=0; byte counter=0; bad sticky=0. iready=0 while irst is high.
- Holding register stores one 64-bit beat with its sideband. All outputs are registered.
- States:
  - EMPTY: no beat held.
  - HI: presenting [63:32].
  - LO: presenting [31:0].
- An accepted beat in EMPTY goes to HI; ovalid=1 on the next cycle. Latency is one cycle.
- HI, on oready: if the beat is single-half, go to EMPTY, or to HI if a new beat is accepted in the same cycle. Otherwise go to LO.
- LO, on oready: go to EMPTY, or to HI if a new beat is accepted in the same cycle.
- iready = ~irst & (state==EMPTY | (oready & the current word is the last half of the held beat)). This sustains 1 beat per 2 cycles with no bubbles.
- Byte counter rem:
  - On an isop beat: rem = iplen.
  - On other beats: rem = the value carried from the previous beat.
  - After each beat: rem_next = (rem>8) ? rem-8 : 0, saturating.
- EOP beat byte count: n = (rem==0 | rem>8) ? 8 : rem.
  - n<=4: single-half; HI word carries oeop, oresidual=n[1:0].
  - n>4: LO word carries oeop, oresidual=(n-4)[1:0].
- Non-eop beats are always two halves with oresidual=0.
- osop is asserted on the HI word of the isop beat only.
- Bad handling: the bad sticky bit ORs in ibad on every accepted beat and clears after the oeop word handshakes. obad = sticky | ibad of the eop beat, presented only with oeop; 0 otherwise.
- Output hold: while ovalid & ~oready, all outputs are held stable and ovalid is never withdrawn.
- A single-beat packet (isop & ieop) is legal.
- iplen=0 is treated as a 8-byte beat (rem==0 rule).
- Reset mid-packet: the held beat, counter and sticky bit are discarded; the next accepted beat must be isop.
- ivalid while iready=0: no state change. Input must hold.

Optional Feature:
- Macro PKT_DOWNSIZER_LEN_CHECK_EN.
- Defined: olen_err pulses for 1 cycle, one cycle after acceptance of any of these beats:
  - (a) ieop beat with rem>8 (length longer than data);
  - (b) non-eop beat with rem<=8 (data longer than length);
  - (c) isop beat accepted while a packet is still open (missing eop);
  - (d) iplen==0.
- For (a), (b) and (d), the packet's obad is forced to 1. For (c), the open packet is terminated with no oeop, and the new packet starts clean.
- Undefined: olen_err is tied 0; framing follows ieop only, using the counter rules above.

Test Plan:
- 13-byte packet, 2 beats, oready=1 -> 4 words: osop on word 0 only; word 3 has oeop=1, oresidual=1; words in order beat0[63:32], beat0[31:0], beat1[63:32], beat1[31:0]; ovalid contiguous.
- 4-byte single beat (isop&ieop, iplen=4) -> one word [63:32] with osop=oeop=1, oresidual=0; iready=1 on the following cycle.
- 3 back-to-back 8-byte packets, ivalid held high -> 6 consecutive ovalid cycles, iready high every 2nd cycle, oresidual=0 on each oeop.
- 11-byte packet with ibad on beat 0 only and oready toggling 1,0,1,0 -> outputs stable during stalls; last word oeop=1, oresidual=3, obad=1; the next packet has obad=0.
- irst asserted while the LO word is stalled -> next cycle ovalid=0, iready=0; after release, a new 4-byte packet emits exactly one word with osop=oeop=1.
- With PKT_DOWNSIZER_LEN_CHECK_EN: iplen=20 with ieop on beat 2 -> olen_err pulse one cycle after beat 2 is accepted, eop word obad=1; without the macro -> olen_err=0 and last word oresidual=0.
